sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single off-chip SRAM between two requesters.
  - Port 0: CPU MAR/MDR path, driven by the instruction sequencer.
  - Port 1: program loader / debug DMA.
- Owns every SRAM strobe and runs fixed-length read and write cycles.
- Returns read data and a one-cycle Ack to the granted port.
- Sits between the CPU memory interface and the SRAM tristate wrapper.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 16, SRAM data width.
- RD_CYCLES, 2, cycles Mem_OE is held low per read; must be >= 1.
- WR_CYCLES, 2, cycles Mem_WE is held low per write; must be >= 1.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Req0  in  1  port 0 request; held high until Ack0.
- We0  in  1  port 0 operation: 1 = write, 0 = read.
- Addr0  in  ADDR_W  port 0 address.
- Wdata0  in  DATA_W  port 0 write data.
- Ack0  out  1  one-cycle completion pulse to port 0.
- Req1, We1, Addr1, Wdata1, Ack1  same as port 0, for port 1.
- Rdata  out  DATA_W  last read word; shared by both ports; valid from the Ack cycle until the next read completes.
- Mem_ADDR  out  ADDR_W  SRAM address.
- Mem_Dout  out  DATA_W  data driven to SRAM.
- Mem_Din  in  DATA_W  data read from SRAM.
- Mem_Drive  out  1  tristate enable for Mem_Dout.
- Mem_CE, Mem_UB, Mem_LB  out  1  tied 0 (always enabled, full-word access).
- Mem_OE, Mem_WE  out  1  active-low read and write strobes.

Behaviour:
- Reset (asynchronous, Reset=0) forces:
  - state IDLE; Mem_OE=1, Mem_WE=1, Mem_Drive=0, Ack0=Ack1=0, Rdata=0, Mem_ADDR=0, Mem_Dout=0;
  - last-grant bit = 1, so port 0 wins the first contention.
- Reset mid-operation aborts the cycle: strobes deassert in the same instant, with no Ack.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - No request: stay in IDLE, all strobes inactive.
  - Exactly one Req high: grant that port.
  - Both Req high: grant the port not granted last (round-robin).
  - At grant: register Addr/Wdata/We into Mem_ADDR/Mem_Dout/op; set the grant bit; load the cycle counter.
  - Go to RD (We=0) or WR (We=1).
- RD:
  - Mem_OE=0 for exactly RD_CYCLES cycles.
  - Rdata <= Mem_Din on the last RD cycle.
  - Then go to DONE.
- WR:
  - Mem_Drive=1 and Mem_WE=0 for exactly WR_CYCLES cycles.
  - Mem_ADDR and Mem_Dout are stable throughout.
  - Then go to DONE.
- DONE:
  - Ack of the granted port = 1 for one cycle; all strobes inactive.
  - Always go to IDLE; there is no back-to-back grant from DONE.
- Latency from Req sampled high in IDLE to Ack high:
  - read: RD_CYCLES+1 cycles;
  - write: WR_CYCLES+1 cycles.
  - Total occupancy per access is RD_CYCLES+2 or WR_CYCLES+2 cycles including IDLE.
- Requester rules:
  - Drop Req in the cycle after Ack.
  - A Req still high in IDLE after Ack is treated as a new request.
  - Req dropped during RD or WR is ignored; the cycle completes and Ack still pulses.
  - Addr/We/Wdata changes after grant are ignored.
- Mem_OE and Mem_WE are never low in the same cycle. Mem_Drive=1 only in WR.
- Cycle counter width is $clog2(max(RD_CYCLES,WR_CYCLES))+1; it counts down to 1 with no wrap.
- Ack0 and Ack1 are never high together.

Optional Feature:
- Macro SRAM_ARB_PRIO0_EN.
- Defined: fixed priority. Port 0 (CPU) wins every contention and the last-grant bit is removed. Port 1 can starve while port 0 requests continuously.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset held 0, then released; Req0=1, We0=0, Addr0=0x00010, SRAM model returns 0x1234 -> Mem_OE low cycles 1-2 after grant, Ack0 high at cycle 3, Rdata=0x1234, Ack1 never high.
- Req1=1, We1=1, Addr1=0x003FF, Wdata1=0xBEEF -> Mem_WE low and Mem_Drive high for 2 cycles with Mem_ADDR=0x003FF and Mem_Dout=0xBEEF; Ack1 one pulse; model holds 0xBEEF at 0x003FF.
- Req0 and Req1 both held continuously (reads), four transactions -> grants alternate 0,1,0,1; each Ack lasts one cycle; an IDLE cycle separates transactions. With SRAM_ARB_PRIO0_EN defined -> grants 0,0,0,0.
- Reset driven to 0 in the first WR cycle -> Mem_WE=1 and Mem_Drive=0 immediately (asynchronous); no Ack; after release the next grant goes to port 0.
- Req0 dropped in the second RD cycle -> Ack0 still pulses, Rdata updated; Addr0 changed mid-cycle has no effect on Mem_ADDR.
- Every cycle of every test: assert not (Mem_OE==0 and Mem_WE==0); assert not (Ack0 and Ack1); Mem_CE=Mem_UB=Mem_LB=0.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Signal bundle between sram_arbiter, its two requesters and the SRAM tristate wrapper.
// slave is the arbiter's view; master is the requesters' and SRAM's view.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
);
  logic              Req0;
  logic              We0;
  logic [ADDR_W-1:0] Addr0;
  logic [DATA_W-1:0] Wdata0;
  logic              Ack0;
  logic              Req1;
  logic              We1;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] Wdata1;
  logic              Ack1;
  logic [DATA_W-1:0] Rdata;
  logic [ADDR_W-1:0] Mem_ADDR;
  logic [DATA_W-1:0] Mem_Dout;
  logic [DATA_W-1:0] Mem_Din;
  logic              Mem_Drive;
  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;

  modport slave (
    input  Req0, We0, Addr0, Wdata0, Req1, We1, Addr1, Wdata1, Mem_Din,
    output Ack0, Ack1, Rdata, Mem_ADDR, Mem_Dout, Mem_Drive, Mem_CE, Mem_UB, Mem_LB,
           Mem_OE, Mem_WE
  );

  modport master (
    output Req0, We0, Addr0, Wdata0, Req1, We1, Addr1, Wdata1, Mem_Din,
    input  Ack0, Ack1, Rdata, Mem_ADDR, Mem_Dout, Mem_Drive, Mem_CE, Mem_UB, Mem_LB,
           Mem_OE, Mem_WE
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter owning the off-chip SRAM strobes; fixed-length read/write cycles.
// Define SRAM_ARB_PRIO0_EN for fixed port-0 priority instead of round-robin.
module sram_arbiter #(
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 2
) (
  input logic           Clk,
  input logic           Reset,
  sram_arbiter_if.slave bus
);

  localparam int unsigned MaxCycles = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pick;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      grant_q <= 1'b1;  // port 1 "went last", so port 0 wins the first contention
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
`ifdef SRAM_ARB_PRIO0_EN
    pick = ~bus.Req0;
`else
    pick = (bus.Req0 & bus.Req1) ? ~grant_q : bus.Req1;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.Req0 | bus.Req1) begin
          grant_d = pick;
          addr_d  = pick ? bus.Addr1 : bus.Addr0;
          dout_d  = pick ? bus.Wdata1 : bus.Wdata0;
          if (pick ? bus.We1 : bus.We0) begin
            state_d = StWr;
            cnt_d   = CntW'(WR_CYCLES);
          end else begin
            state_d = StRd;
            cnt_d   = CntW'(RD_CYCLES);
          end
        end
      end
      StRd: begin
        if (cnt_q == CntW'(1)) begin
          rdata_d = bus.Mem_Din;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWr: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode straight from state so an asynchronous reset releases them at once.
  assign bus.Mem_OE    = (state_q != StRd);
  assign bus.Mem_WE    = (state_q != StWr);
  assign bus.Mem_Drive = (state_q == StWr);
  assign bus.Ack0      = (state_q == StDone) & ~grant_q;
  assign bus.Ack1      = (state_q == StDone) & grant_q;
  assign bus.Rdata     = rdata_q;
  assign bus.Mem_ADDR  = addr_q;
  assign bus.Mem_Dout  = dout_q;
  assign bus.Mem_CE    = 1'b0;
  assign bus.Mem_UB    = 1'b0;
  assign bus.Mem_LB    = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter: transaction-level reference model plus a small SRAM model.
module tb_sram_arbiter;
  localparam int unsigned AddrW    = 20;
  localparam int unsigned DataW    = 16;
  localparam int unsigned RdCycles = 2;
  localparam int unsigned WrCycles = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          last_grant = 1'b1;
  bit          cur_winner = 1'b0;
  logic [15:0] exp_rdata = 16'h0;
  logic [15:0] ref_mem [1024];
  logic [15:0] sram [1024];
  bit          sram_ready = 1'b0;

  sram_arbiter_if #(.ADDR_W(AddrW), .DATA_W(DataW)) bus ();

  sram_arbiter #(
    .ADDR_W   (AddrW),
    .DATA_W   (DataW),
    .RD_CYCLES(RdCycles),
    .WR_CYCLES(WrCycles)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] init_word(input int i);
    if (i == 16) return 16'h1234;
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  // SRAM model: address aliases onto 1K words; writes land while WE is low.
  always @(posedge Clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 1024; i++) sram[i] = init_word(i);
      sram_ready = 1'b1;
    end else if (!bus.Mem_WE && bus.Mem_Drive) begin
      sram[bus.Mem_ADDR[9:0]] = bus.Mem_Dout;
    end
  end

  assign bus.Mem_Din = sram[bus.Mem_ADDR[9:0]];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    check_eq("oe_we_overlap", 32'(!bus.Mem_OE && !bus.Mem_WE), 0);
    check_eq("ack_overlap", 32'(bus.Ack0 && bus.Ack1), 0);
    check_eq("ce_ub_lb", 32'({bus.Mem_CE, bus.Mem_UB, bus.Mem_LB}), 0);
  end

  task automatic drive_req(input bit port, input bit req, input bit we,
                           input logic [19:0] a, input logic [15:0] d);
    if (port) begin
      bus.Req1 = req; bus.We1 = we; bus.Addr1 = a; bus.Wdata1 = d;
    end else begin
      bus.Req0 = req; bus.We0 = we; bus.Addr0 = a; bus.Wdata0 = d;
    end
  endtask

  task automatic rand_req(input bit port);
    drive_req(port, 1'b1, 1'($urandom_range(0, 1)), 20'($urandom_range(0, 1023)),
              16'($urandom));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_oe"}, 32'(bus.Mem_OE), 1);
    check_eq({tag, "_we"}, 32'(bus.Mem_WE), 1);
    check_eq({tag, "_drive"}, 32'(bus.Mem_Drive), 0);
    check_eq({tag, "_ack"}, 32'({bus.Ack1, bus.Ack0}), 0);
    check_eq({tag, "_rdata"}, 32'(bus.Rdata), 32'(exp_rdata));
  endtask

  // Called at a falling edge in an idle cycle with requests already driven; returns at the
  // falling edge of the expected Ack cycle. ack_port is what the DUT actually acknowledged.
  task automatic run_txn(input bit do_mutate, output bit ack_port);
    bit          w;
    bit          we;
    logic [19:0] a;
    logic [15:0] d;
    int          len;
    check_idle("pre_grant");
    if (bus.Req0 && bus.Req1) begin
`ifdef SRAM_ARB_PRIO0_EN
      w = 1'b0;
`else
      w = (last_grant == 1'b1) ? 1'b0 : 1'b1;
`endif
    end else begin
      w = bus.Req1;
    end
    last_grant = w;
    cur_winner = w;
    we  = w ? bus.We1 : bus.We0;
    a   = w ? bus.Addr1 : bus.Addr0;
    d   = w ? bus.Wdata1 : bus.Wdata0;
    len = we ? int'(WrCycles) : int'(RdCycles);
    for (int k = 1; k <= len; k++) begin
      @(negedge Clk);
      check_eq("strobe_oe", 32'(bus.Mem_OE), 32'(we));
      check_eq("strobe_we", 32'(bus.Mem_WE), 32'(!we));
      check_eq("mem_drive", 32'(bus.Mem_Drive), 32'(we));
      check_eq("mem_addr", 32'(bus.Mem_ADDR), 32'(a));
      if (we) check_eq("mem_dout", 32'(bus.Mem_Dout), 32'(d));
      check_eq("early_ack", 32'({bus.Ack1, bus.Ack0}), 0);
      check_eq("rdata_hold", 32'(bus.Rdata), 32'(exp_rdata));
      if (do_mutate) begin
        if (w) begin
          bus.Addr1 = a ^ 20'h155; bus.Wdata1 = ~d; bus.We1 = ~we;
          if (k == 2) bus.Req1 = 1'b0;
        end else begin
          bus.Addr0 = a ^ 20'h155; bus.Wdata0 = ~d; bus.We0 = ~we;
          if (k == 2) bus.Req0 = 1'b0;
        end
      end
    end
    @(negedge Clk);
    if (we) ref_mem[a[9:0]] = d;
    else    exp_rdata = ref_mem[a[9:0]];
    check_eq("ack0", 32'(bus.Ack0), 32'(!w));
    check_eq("ack1", 32'(bus.Ack1), 32'(w));
    check_eq("done_oe", 32'(bus.Mem_OE), 1);
    check_eq("done_we", 32'(bus.Mem_WE), 1);
    check_eq("done_drive", 32'(bus.Mem_Drive), 0);
    check_eq("rdata", 32'(bus.Rdata), 32'(exp_rdata));
    if (we) check_eq("sram_content", 32'(sram[a[9:0]]), 32'(d));
    ack_port = bus.Ack1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          p;
    int unsigned r;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    drive_req(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    repeat (3) @(negedge Clk);
    check_eq("rst_oe", 32'(bus.Mem_OE), 1);
    check_eq("rst_we", 32'(bus.Mem_WE), 1);
    check_eq("rst_drive", 32'(bus.Mem_Drive), 0);
    check_eq("rst_ack", 32'({bus.Ack1, bus.Ack0}), 0);
    check_eq("rst_rdata", 32'(bus.Rdata), 0);
    check_eq("rst_addr", 32'(bus.Mem_ADDR), 0);
    check_eq("rst_dout", 32'(bus.Mem_Dout), 0);
    Reset = 1'b1;
    @(negedge Clk);

    // Single read from port 0
    drive_req(1'b0, 1'b1, 1'b0, 20'h00010, 16'h0);
    run_txn(1'b0, p);
    check_eq("first_grant", 32'(p), 0);
    check_eq("rd_0x1234", 32'(bus.Rdata), 32'h1234);
    drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    @(negedge Clk);

    // Single write from port 1
    drive_req(1'b1, 1'b1, 1'b1, 20'h003FF, 16'hBEEF);
    run_txn(1'b0, p);
    check_eq("wr_grant", 32'(p), 1);
    check_eq("wr_sram_beef", 32'(sram[1023]), 32'hBEEF);
    drive_req(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    @(negedge Clk);

    // Both ports read continuously
    drive_req(1'b0, 1'b1, 1'b0, 20'h00021, 16'h0);
    drive_req(1'b1, 1'b1, 1'b0, 20'h00222, 16'h0);
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, p);
`ifdef SRAM_ARB_PRIO0_EN
      check_eq("prio_grant", 32'(p), 0);
`else
      check_eq("rr_grant", 32'(p), 32'(i % 2));
`endif
      if (i == 3) begin
        drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
        drive_req(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
      end
      @(negedge Clk);
    end

    // Req0 dropped and Addr0 changed mid-read
    drive_req(1'b0, 1'b1, 1'b0, 20'h00155, 16'h0);
    run_txn(1'b1, p);
    check_eq("drop_ack", 32'(p), 0);
    drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    @(negedge Clk);

    // Reset during the first write cycle
    drive_req(1'b1, 1'b1, 1'b1, 20'h00077, 16'hCAFE);
    check_idle("pre_abort");
    @(negedge Clk);
    check_eq("abort_wr_started", 32'(bus.Mem_WE), 0);
    Reset = 1'b0;
    #1;
    check_eq("abort_we", 32'(bus.Mem_WE), 1);
    check_eq("abort_drive", 32'(bus.Mem_Drive), 0);
    check_eq("abort_oe", 32'(bus.Mem_OE), 1);
    drive_req(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    exp_rdata  = 16'h0;
    last_grant = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check_eq("abort_ack", 32'({bus.Ack1, bus.Ack0}), 0);
    end
    Reset = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check_idle("post_rst");
    end
    check_eq("aborted_wr_sram", 32'(sram[10'h077]), 32'(ref_mem[10'h077]));
    drive_req(1'b0, 1'b1, 1'b0, 20'h00044, 16'h0);
    drive_req(1'b1, 1'b1, 1'b0, 20'h00045, 16'h0);
    run_txn(1'b0, p);
    check_eq("post_rst_grant", 32'(p), 0);

    // Random traffic: the loser keeps waiting, the winner re-requests or goes quiet
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) rand_req(cur_winner);
      else drive_req(cur_winner, 1'b0, 1'b0, 20'h0, 16'h0);
      @(negedge Clk);
      if (!bus.Req0 && !bus.Req1) begin
        repeat ($urandom_range(0, 2)) begin
          check_idle("gap");
          @(negedge Clk);
        end
        r = $urandom_range(1, 3);
        if (r[0]) rand_req(1'b0);
        if (r[1]) rand_req(1'b1);
      end
      run_txn(1'($urandom_range(0, 1)), p);
    end

    drive_req(1'b0, 1'b0, 1'b0, 20'h0, 16'h0);
    drive_req(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    @(negedge Clk);
    check_idle("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
